// File: rtl/nascom_pkg.sv
// Shared types and widths for the NASCOM video RAM arbiter.
package nascom_pkg;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      VRD,
      CRD,
      CWS,
      CWP,
      CWH
   } state_e;

endpackage

// File: rtl/nascom_timer.sv
// Loadable down-counter with a registered zero flag; times read and write-pulse phases.
module nascom_timer #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         zero_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= (cnt_d == '0);
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/nascom_vram_arbiter.sv
// Shares the MK4118 video SRAM between the CPU port and the fixed-priority video fetch port,
// sequencing chip enable, output enable, write enable and data drive.
module nascom_vram_arbiter
   import nascom_pkg::*;
#(
   parameter int unsigned RD_CYCLES  = 2,
   parameter int unsigned WR_PULSE   = 1,
   parameter int unsigned LATE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [DATA_W-1:0] vid_rdata,
   output logic              vid_late,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_ce_n,
   output logic              ram_oe_n,
   output logic              ram_we_n,
   output logic [DATA_W-1:0] ram_d_out,
   output logic              ram_d_oe,
   input  logic [DATA_W-1:0] ram_d_in
);

   localparam int unsigned TMR_MAX = (RD_CYCLES > WR_PULSE) ? RD_CYCLES : WR_PULSE;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
   localparam int unsigned LW      = $clog2(LATE_LIMIT + 2);

   state_e             state_q, state_d;
   logic               tmr_load, tmr_dec, tmr_zero;
   logic [TMR_W-1:0]   tmr_val;
   logic [LW-1:0]      wait_q, wait_d;
   logic               vid_late_q, vid_late_d;
   logic               vid_grant;

   logic               ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, d_oe_q, d_oe_d;
   logic [ADDR_W-1:0]  ram_a_q, ram_a_d;
   logic [DATA_W-1:0]  ram_d_out_q, ram_d_out_d;
   logic               cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d;
   logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d, vid_rdata_q, vid_rdata_d;

   nascom_timer #(.W(TMR_W)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Grants are masked during an ack cycle: that clock is the bus turnaround and the
   // acked requester still shows its old request.
   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      tmr_val  = TMR_W'(RD_CYCLES - 1);
      case (state_q)
         IDLE: begin
            if (!(cpu_ack_q || vid_ack_q)) begin
               if (vid_req) begin
                  state_d  = VRD;
                  tmr_load = 1'b1;
               end else if (cpu_req) begin
                  state_d  = cpu_we ? CWS : CRD;
                  tmr_load = !cpu_we;
               end
            end
         end
         VRD, CRD: begin
            if (tmr_zero) state_d = IDLE;
            else          tmr_dec = 1'b1;
         end
         CWS: begin
            state_d  = CWP;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(WR_PULSE - 1);
         end
         CWP: begin
            if (tmr_zero) state_d = CWH;
            else          tmr_dec = 1'b1;
         end
         CWH:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pin and handshake values for the coming clock, decoded from the next state.
   always_comb begin
      ce_n_d      = 1'b1;
      oe_n_d      = 1'b1;
      we_n_d      = 1'b1;
      d_oe_d      = 1'b0;
      ram_a_d     = ram_a_q;
      ram_d_out_d = ram_d_out_q;
      cpu_ack_d   = 1'b0;
      vid_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      vid_rdata_d = vid_rdata_q;
      case (state_d)
         VRD, CRD: begin
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
         end
         CWS, CWH: begin
            ce_n_d = 1'b0;
            d_oe_d = 1'b1;
         end
         CWP: begin
            ce_n_d = 1'b0;
            we_n_d = 1'b0;
            d_oe_d = 1'b1;
         end
         default: ;
      endcase
      if (state_q == IDLE) begin
         if (state_d == VRD)       ram_a_d = vid_addr;
         else if (state_d != IDLE) ram_a_d = cpu_addr;
         if (state_d == CWS)       ram_d_out_d = cpu_wdata;
      end
      if ((state_q == VRD) && (state_d == IDLE)) begin
         vid_ack_d   = 1'b1;
         vid_rdata_d = ram_d_in;
      end
      if ((state_q == CRD) && (state_d == IDLE)) begin
         cpu_ack_d   = 1'b1;
         cpu_rdata_d = ram_d_in;
      end
      if (state_d == CWH) cpu_ack_d = 1'b1;
   end

   // Video wait counter: counts clocks a fresh video request sits ungranted.
   always_comb begin
      vid_grant = (state_q == IDLE) && (state_d == VRD);
      wait_d    = wait_q;
      if (vid_grant) begin
         wait_d = '0;
      end else if (vid_req && !vid_ack_q && (state_q != VRD) && (wait_q <= LW'(LATE_LIMIT))) begin
         wait_d = wait_q + LW'(1);
      end
      vid_late_d = vid_late_q || (wait_d > LW'(LATE_LIMIT));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         d_oe_q      <= 1'b0;
         ram_a_q     <= '0;
         ram_d_out_q <= '0;
         cpu_ack_q   <= 1'b0;
         vid_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         vid_rdata_q <= '0;
         wait_q      <= '0;
         vid_late_q  <= 1'b0;
      end else begin
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         d_oe_q      <= d_oe_d;
         ram_a_q     <= ram_a_d;
         ram_d_out_q <= ram_d_out_d;
         cpu_ack_q   <= cpu_ack_d;
         vid_ack_q   <= vid_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         vid_rdata_q <= vid_rdata_d;
         wait_q      <= wait_d;
         vid_late_q  <= vid_late_d;
      end
   end

   assign ram_ce_n  = ce_n_q;
   assign ram_oe_n  = oe_n_q;
   assign ram_we_n  = we_n_q;
   assign ram_d_oe  = d_oe_q;
   assign ram_a     = ram_a_q;
   assign ram_d_out = ram_d_out_q;
   assign cpu_ack   = cpu_ack_q;
   assign vid_ack   = vid_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign vid_rdata = vid_rdata_q;
   assign vid_late  = vid_late_q;

endmodule

// File: tb/tb_nascom_vram_arbiter.sv
// Bench for nascom_vram_arbiter: directed scenarios plus random traffic against a
// schedule-level reference model; a second instance runs with LATE_LIMIT=1.
module tb_nascom_vram_arbiter;

   localparam int unsigned RD = 2;
   localparam int unsigned WR = 1;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cpu_req, cpu_we, vid_req;
   logic [9:0] cpu_addr, vid_addr;
   logic [7:0] cpu_wdata;
   logic [7:0] ram_d_in;

   logic       cpu_ack, vid_ack, vid_late, ram_ce_n, ram_oe_n, ram_we_n, ram_d_oe;
   logic [7:0] cpu_rdata, vid_rdata, ram_d_out;
   logic [9:0] ram_a;
   logic       l1_cpu_ack, l1_vid_ack, l1_vid_late, l1_ce_n, l1_oe_n, l1_we_n, l1_d_oe;
   logic [7:0] l1_cpu_rdata, l1_vid_rdata, l1_d_out;
   logic [9:0] l1_a;

   logic [7:0] sram    [1024];
   logic [7:0] ref_mem [1024];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // reference model: kind 0 none, 1 video read, 2 cpu read, 3 cpu write
   int         kind, g, endc, ac, free_at, wait_n;
   logic [7:0] rdval, dout_e, crd_e, vrd_e;
   logic [9:0] a_e;
   logic [3:0] pins_e;
   bit         late4, late1, cack_now, vack_now;
   int         cpu_ack_cyc = -100, vid_ack_cyc = -100, cpu_acks = 0, vid_acks = 0, we_low = 0;

   always #5 clk = ~clk;

   assign ram_d_in = (!ram_ce_n && !ram_oe_n) ? sram[ram_a] : 8'h00;

   always @(negedge clk) if (!ram_ce_n && !ram_we_n) sram[ram_a] <= ram_d_out;

   nascom_vram_arbiter #(.RD_CYCLES(RD), .WR_PULSE(WR), .LATE_LIMIT(4)) dut (
      .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .vid_req(vid_req),
      .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata), .vid_late(vid_late),
      .ram_a(ram_a), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
      .ram_d_out(ram_d_out), .ram_d_oe(ram_d_oe), .ram_d_in(ram_d_in));

   nascom_vram_arbiter #(.RD_CYCLES(RD), .WR_PULSE(WR), .LATE_LIMIT(1)) dut_l1 (
      .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(l1_cpu_ack), .cpu_rdata(l1_cpu_rdata), .vid_req(vid_req),
      .vid_addr(vid_addr), .vid_ack(l1_vid_ack), .vid_rdata(l1_vid_rdata), .vid_late(l1_vid_late),
      .ram_a(l1_a), .ram_ce_n(l1_ce_n), .ram_oe_n(l1_oe_n), .ram_we_n(l1_we_n),
      .ram_d_out(l1_d_out), .ram_d_oe(l1_d_oe), .ram_d_in(ram_d_in));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_outs(input string p, input logic ce, oe, we, doe,
                             input logic [9:0] a, input logic [7:0] dout,
                             input logic ca, va, input logic [7:0] crd, vrd,
                             input logic late, late_e);
      chk({p, "pins"}, {ce, oe, we, doe}, pins_e);
      chk({p, "ram_a"}, a, a_e);
      chk({p, "d_out"}, dout, dout_e);
      chk({p, "acks"}, {ca, va}, {cack_now, vack_now});
      chk({p, "cpu_rdata"}, crd, crd_e);
      chk({p, "vid_rdata"}, vrd, vrd_e);
      chk({p, "vid_late"}, late, late_e);
   endtask

   task automatic model_reset();
      kind = 0; g = 0; endc = 0; ac = -1; free_at = 0; wait_n = 0;
      a_e = '0; dout_e = '0; crd_e = '0; vrd_e = '0; late4 = 0; late1 = 0;
   endtask

   task automatic check_cycle();
      bit act;
      cack_now = 0;
      vack_now = 0;
      if (kind != 0 && cyc == ac) begin
         if (kind == 1) begin
            vack_now = 1; vrd_e = rdval;
         end else begin
            cack_now = 1;
            if (kind == 2) crd_e = rdval;
         end
      end
      act    = (kind != 0) && (cyc > g) && (cyc <= endc);
      pins_e = {!act, !(act && kind != 3),
                !(kind == 3 && cyc >= g + 2 && cyc <= g + 1 + int'(WR)), act && kind == 3};
      check_outs("d4_", ram_ce_n, ram_oe_n, ram_we_n, ram_d_oe, ram_a, ram_d_out,
                 cpu_ack, vid_ack, cpu_rdata, vid_rdata, vid_late, late4);
      check_outs("d1_", l1_ce_n, l1_oe_n, l1_we_n, l1_d_oe, l1_a, l1_d_out,
                 l1_cpu_ack, l1_vid_ack, l1_cpu_rdata, l1_vid_rdata, l1_vid_late, late1);
      chk("bus_fight", !ram_oe_n && ram_d_oe, 1'b0);
      if (cpu_ack) begin cpu_ack_cyc = cyc; cpu_acks++; end
      if (vid_ack) begin vid_ack_cyc = cyc; vid_acks++; end
      if (!ram_we_n) we_low++;
   endtask

   // One access at a time; video wins whenever the bus is free.
   task automatic model_decide();
      bit vgrant;
      vgrant = 0;
      if (!reset_n) return;
      if (cyc >= free_at && (vid_req || cpu_req)) begin
         g = cyc;
         if (vid_req) begin
            kind = 1; vgrant = 1; a_e = vid_addr; rdval = ref_mem[vid_addr];
            endc = g + RD; ac = g + RD + 1; free_at = g + RD + 2;
         end else begin
            a_e = cpu_addr;
            if (cpu_we) begin
               kind = 3; ref_mem[cpu_addr] = cpu_wdata; dout_e = cpu_wdata;
               endc = g + WR + 2; ac = g + WR + 2; free_at = g + WR + 3;
            end else begin
               kind = 2; rdval = ref_mem[cpu_addr];
               endc = g + RD; ac = g + RD + 1; free_at = g + RD + 2;
            end
         end
      end
      if (vgrant) wait_n = 0;
      else if (vid_req && !(kind == 1 && cyc > g && cyc <= ac)) wait_n++;
      if (wait_n > 4) late4 = 1;
      if (wait_n > 1) late1 = 1;
   endtask

   task automatic tick();
      @(negedge clk);
      check_cycle();
      model_decide();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         tick();
         if (cack_now) cpu_req = 1'b0;
         if (vack_now) vid_req = 1'b0;
      end
   endtask

   task automatic apply_reset(input int n);
      reset_n = 1'b0;
      model_reset();
      run(n);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int rel, base, vbase;
      for (int i = 0; i < 1024; i++) begin
         sram[i]    = 8'($urandom);
         ref_mem[i] = sram[i];
      end
      reset_n = 1'b0; cpu_we = 1'b0; vid_req = 1'b0;
      cpu_req = 1'b1; cpu_addr = 10'h3A5; cpu_wdata = 8'h00; vid_addr = 10'h000;
      model_reset();

      // reset held with a CPU read pending
      run(3);
      chk("rst_pins", {ram_ce_n, ram_oe_n, ram_we_n, ram_d_oe}, 4'b1110);
      chk("rst_noack", 64'(cpu_acks), 64'd0);
      reset_n = 1'b1;
      rel = cyc;
      run(6);
      chk("rst_latency", 64'(cpu_ack_cyc - rel), 64'(RD + 1));

      // write then read back
      we_low = 0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3A5; cpu_wdata = 8'h5C;
      run(6);
      chk("we_pulse_len", 64'(we_low), 64'(WR));
      cpu_req = 1'b1; cpu_we = 1'b0;
      run(6);
      chk("read_back", cpu_rdata, 8'h5C);

      // simultaneous requests: video first
      vid_req = 1'b1; vid_addr = 10'h3A5;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h001;
      run(12);
      chk("sim_order", 64'(cpu_ack_cyc - vid_ack_cyc), 64'd4);
      chk("sim_vid_data", vid_rdata, 8'h5C);

      // video arrives during the write pulse
      apply_reset(2);
      we_low = 0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h155; cpu_wdata = 8'hA7;
      run(2);
      vid_req = 1'b1; vid_addr = 10'h155;
      run(10);
      chk("cwp_no_abort", 64'(we_low), 64'(WR));
      chk("cwp_vid_data", vid_rdata, 8'hA7);
      chk("cwp_late_l4", vid_late, 1'b0);
      chk("cwp_late_l1", l1_vid_late, 1'b1);

      // reset in the middle of a CPU read
      apply_reset(2);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3A5;
      run(1);
      base = cpu_acks;
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_pins", {ram_ce_n, ram_oe_n, l1_ce_n, l1_oe_n}, 4'b1111);
      cpu_req = 1'b0;
      run(3);
      reset_n = 1'b1;
      run(4);
      chk("midrst_noack", 64'(cpu_acks - base), 64'd0);

      // continuous video traffic starves a pending CPU read
      base = cpu_acks; vbase = vid_acks;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h000;
      vid_req = 1'b1; vid_addr = 10'h010;
      repeat (40) begin
         tick();
         if (vack_now) vid_addr = 10'($urandom);
      end
      chk("starve_cpu", 64'(cpu_acks - base), 64'd0);
      chk("starve_vid", 64'(vid_acks - vbase), 64'd10);
      chk("starve_late", {vid_late, l1_vid_late}, 2'b00);
      vid_req = 1'b0;
      run(8);
      chk("starve_release", 64'(cpu_acks - base), 64'd1);

      // random traffic
      apply_reset(2);
      repeat (400) begin
         run(1);
         if (!cpu_req && $urandom_range(0, 3) == 0) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom);
            cpu_addr = 10'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
         end
         if (!vid_req && $urandom_range(0, 3) == 0) begin
            vid_req = 1'b1; vid_addr = 10'($urandom_range(0, 15));
         end
      end
      repeat (20) begin
         run(1);
         if (!cpu_req) cpu_we = 1'b0;
      end
      cpu_req = 1'b0; vid_req = 1'b0;
      run(8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
